mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the wasm/cpu memory arbiter.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 255;
   localparam int CNT_W       = 9;

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t DONE  = 2'd2;

   typedef enum logic {
      GNT_WASM = 1'b0,
      GNT_CPU  = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester handshakes plus the shared memory port.
// slave = arbiter side, master = requesters and memory model.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 8
);
   logic              boot_done;

   logic              wasm_req;
   logic              wasm_we;
   logic [ADDR_W-1:0] wasm_addr;
   logic [DATA_W-1:0] wasm_wdata;
   logic              wasm_ack;
   logic              wasm_err;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic              cpu_err;

   logic [DATA_W-1:0] rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_read_en;
   logic              mem_write_en;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_ready;

   modport slave (
      input  boot_done,
      input  wasm_req, wasm_we, wasm_addr, wasm_wdata,
      output wasm_ack, wasm_err,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ack, cpu_err,
      output rdata,
      output mem_addr, mem_data_in, mem_read_en, mem_write_en,
      input  mem_data_out, mem_ready
   );

   modport master (
      output boot_done,
      output wasm_req, wasm_we, wasm_addr, wasm_wdata,
      input  wasm_ack, wasm_err,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ack, cpu_err,
      input  rdata,
      input  mem_addr, mem_data_in, mem_read_en, mem_write_en,
      output mem_data_out, mem_ready
   );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates wasm loader and cpu accesses onto one memory port (IDLE/ISSUE/DONE).
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating priority; otherwise wasm always wins.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state;
   gnt_t              gnt;
   gnt_t              pick;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [CNT_W-1:0]  cnt;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              cpu_elig;
   logic              any_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic              prio_cpu;
`endif

   // cpu stays pending (not dropped) until the ROM has been mapped
   assign cpu_elig = bus.cpu_req & bus.boot_done;
   assign any_req  = bus.wasm_req | cpu_elig;

   always_comb begin
      // NOTE: default assigned first so no path leaves pick unassigned (no latch).
      pick = GNT_WASM;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (cpu_elig && (!bus.wasm_req || prio_cpu)) pick = GNT_CPU;
`else
      if (cpu_elig && !bus.wasm_req) pick = GNT_CPU;
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignment so every reader sees pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= GNT_WASM;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         cnt       <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         prio_cpu  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (any_req) begin
               gnt       <= pick;
               lat_we    <= (pick == GNT_CPU) ? bus.cpu_we    : bus.wasm_we;
               lat_addr  <= (pick == GNT_CPU) ? bus.cpu_addr  : bus.wasm_addr;
               lat_wdata <= (pick == GNT_CPU) ? bus.cpu_wdata : bus.wasm_wdata;
               cnt       <= '0;
               err_q     <= 1'b0;
               state     <= ISSUE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
               prio_cpu  <= (pick == GNT_WASM);
`endif
            end
            ISSUE: begin
               cnt <= cnt + 1'b1;
               // ready on the final counted cycle still wins over timeout
               if (bus.mem_ready) begin
                  if (!lat_we) rdata_q <= bus.mem_data_out;
                  state <= DONE;
               end else if (cnt == CNT_LAST) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_read_en  = (state == ISSUE) && !lat_we;
   assign bus.mem_write_en = (state == ISSUE) &&  lat_we;
   assign bus.mem_addr     = lat_addr;
   assign bus.mem_data_in  = lat_wdata;
   assign bus.rdata        = rdata_q;
   assign bus.wasm_ack     = (state == DONE) && (gnt == GNT_WASM);
   assign bus.cpu_ack      = (state == DONE) && (gnt == GNT_CPU);
   assign bus.wasm_err     = bus.wasm_ack & err_q;
   assign bus.cpu_err      = bus.cpu_ack  & err_q;

endmodule
